db_req_gen: RTL

DB_REQ_GEN -- requirements
Module: db_req_gen

---
 rtl/db_req_if.sv | 47 ++++
 rtl/db_req_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/db_req_if.sv
// db_req_if: bundles the parser request handshake, the DB request/response
// bus, the decision strobe and the statistics outputs of db_req_gen.
// The slave modport is the db_req_gen view; master is the surrounding logic.
interface db_req_if #(
  parameter int HASH_SIZE = 32,
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32
);
  // parser request
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [3:0]           pkt_op;
  logic [KEY_SIZE-1:0]  pkt_key;
  logic [VAL_SIZE-1:0]  pkt_value;
  // request toward the DB
  logic                 db_valid;
  logic [3:0]           db_op;
  logic [HASH_SIZE-1:0] db_hash;
  logic [KEY_SIZE-1:0]  db_key;
  logic [VAL_SIZE-1:0]  db_value;
  // DB response
  logic                 db_rsp_valid;
  logic [3:0]           db_rsp_flag;
  // decision
  logic                 dec_valid;
  logic                 dec_hit;
  logic [3:0]           dec_flag;
  logic                 dec_drop;
  // statistics
  logic [31:0]          stat_req;
  logic [31:0]          stat_hit;
  logic [31:0]          stat_tmo;

  modport slave (
    input  pkt_valid, pkt_op, pkt_key, pkt_value, db_rsp_valid, db_rsp_flag,
    output pkt_ready, db_valid, db_op, db_hash, db_key, db_value,
    output dec_valid, dec_hit, dec_flag, dec_drop,
    output stat_req, stat_hit, stat_tmo
  );

  modport master (
    output pkt_valid, pkt_op, pkt_key, pkt_value, db_rsp_valid, db_rsp_flag,
    input  pkt_ready, db_valid, db_op, db_hash, db_key, db_value,
    input  dec_valid, dec_hit, dec_flag, dec_drop,
    input  stat_req, stat_hit, stat_tmo
  );
endinterface

// File: rtl/db_req_gen.sv
// db_req_gen: accepts one parser request at a time, issues a single-cycle
// hashed lookup to the DB, waits up to TIMEOUT cycles for the response and
// emits a one-cycle decision, then idles GUARD cycles before the next request.
// Optional macro DB_REQ_STATS_EN builds saturating request/hit/timeout
// counters; without it the stat_* outputs are tied to zero.
module db_req_gen #(
  parameter int HASH_SIZE = 32,
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32,
  parameter int TIMEOUT   = 8,
  parameter int GUARD     = 2
) (
  input logic   clk,
  input logic   rst,
  db_req_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  // WAIT counts down from TIMEOUT-1 so that the zero count marks the last
  // WAIT cycle; GUARD counts down from GUARD after the decision cycle.
  localparam logic [7:0] WAIT_LOAD  = 8'(TIMEOUT - 1);
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD);

  state_t               state_reg, state_next;
  logic [7:0]           wait_cnt_reg, wait_cnt_next;
  logic [3:0]           guard_cnt_reg, guard_cnt_next;
  logic                 accept;

  logic [3:0]           op_reg;
  logic [HASH_SIZE-1:0] hash_reg;
  logic [KEY_SIZE-1:0]  key_reg;
  logic [VAL_SIZE-1:0]  value_reg;
  logic                 db_valid_reg;

  logic                 dec_valid_reg, dec_valid_next;
  logic                 dec_hit_reg, dec_hit_next;
  logic [3:0]           dec_flag_reg, dec_flag_next;
  logic                 dec_drop_reg, dec_drop_next;

  // Key split into three hash-wide words, folded together by XOR.
  logic [HASH_SIZE-1:0] key_word [3];
  logic [HASH_SIZE-1:0] hash_fold;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key_word
      assign key_word[gi] = bus.pkt_key[gi*HASH_SIZE +: HASH_SIZE];
    end
  endgenerate

  assign hash_fold = key_word[0] ^ key_word[1] ^ key_word[2];

  // Ready only while idle and not being reset, so it reads 0 during rst.
  assign bus.pkt_ready = (state_reg == ST_IDLE) && !rst;

  // Next-state logic, counters and the decision that is registered next cycle.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    guard_cnt_next = guard_cnt_reg;
    accept         = 1'b0;
    dec_valid_next = 1'b0;
    dec_hit_next   = 1'b0;
    dec_flag_next  = 4'd0;
    dec_drop_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.pkt_valid) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next    = ST_WAIT;
        wait_cnt_next = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (bus.db_rsp_valid) begin
          // A response in the last WAIT cycle still counts as a hit.
          dec_valid_next = 1'b1;
          dec_hit_next   = 1'b1;
          dec_flag_next  = bus.db_rsp_flag;
          dec_drop_next  = (bus.db_rsp_flag[3:2] == 2'b01); // ARREST or FILTERED
          state_next     = ST_GUARD;
          guard_cnt_next = GUARD_LOAD;
        end else if (wait_cnt_reg == 8'd0) begin
          dec_valid_next = 1'b1;
          state_next     = ST_GUARD;
          guard_cnt_next = GUARD_LOAD;
        end else begin
          wait_cnt_next = wait_cnt_reg - 8'd1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          guard_cnt_next = guard_cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, request latch and registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 8'd0;
      guard_cnt_reg <= 4'd0;
      op_reg        <= 4'd0;
      hash_reg      <= '0;
      key_reg       <= '0;
      value_reg     <= '0;
      db_valid_reg  <= 1'b0;
      dec_valid_reg <= 1'b0;
      dec_hit_reg   <= 1'b0;
      dec_flag_reg  <= 4'd0;
      dec_drop_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      guard_cnt_reg <= guard_cnt_next;
      db_valid_reg  <= accept;
      dec_valid_reg <= dec_valid_next;
      dec_hit_reg   <= dec_hit_next;
      dec_flag_reg  <= dec_flag_next;
      dec_drop_reg  <= dec_drop_next;
      if (accept) begin
        op_reg    <= bus.pkt_op;
        hash_reg  <= hash_fold;
        key_reg   <= bus.pkt_key;
        value_reg <= bus.pkt_value;
      end
    end
  end

  assign bus.db_valid  = db_valid_reg;
  assign bus.db_op     = op_reg;
  assign bus.db_hash   = hash_reg;
  assign bus.db_key    = key_reg;
  assign bus.db_value  = value_reg;
  assign bus.dec_valid = dec_valid_reg;
  assign bus.dec_hit   = dec_hit_reg;
  assign bus.dec_flag  = dec_flag_reg;
  assign bus.dec_drop  = dec_drop_reg;

`ifdef DB_REQ_STATS_EN
  logic [31:0] stat_req_reg;
  logic [31:0] stat_hit_reg;
  logic [31:0] stat_tmo_reg;

  // Saturating event counters for issued requests, hits and timeouts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_reg <= 32'd0;
      stat_hit_reg <= 32'd0;
      stat_tmo_reg <= 32'd0;
    end else begin
      if (db_valid_reg && (stat_req_reg != 32'hFFFF_FFFF))
        stat_req_reg <= stat_req_reg + 32'd1;
      if (dec_valid_reg && dec_hit_reg && (stat_hit_reg != 32'hFFFF_FFFF))
        stat_hit_reg <= stat_hit_reg + 32'd1;
      if (dec_valid_reg && !dec_hit_reg && (stat_tmo_reg != 32'hFFFF_FFFF))
        stat_tmo_reg <= stat_tmo_reg + 32'd1;
    end
  end

  assign bus.stat_req = stat_req_reg;
  assign bus.stat_hit = stat_hit_reg;
  assign bus.stat_tmo = stat_tmo_reg;
`else
  assign bus.stat_req = 32'd0;
  assign bus.stat_hit = 32'd0;
  assign bus.stat_tmo = 32'd0;
`endif

endmodule
